// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter width: max(1, clog2(w)), enough to reach w-1 without wrapping.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_sub_bit.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, bout = borrow.
module serial_sub_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - borrow_in controller, one bit per RUN cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             borrow_out
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] res_sr_q;
   logic             br_q;
   logic [CW-1:0]    cnt_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             a_msb_q;
   logic             b_msb_q;
`endif

   logic             bit_d;
   logic             br_d;
   logic [WIDTH-1:0] res_d;
   logic             last_c;

   serial_sub_bit u_bit (
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .bin  (br_q),
      .d    (bit_d),
      .bout (br_d)
   );

   // New result bit enters at the MSB; after WIDTH shifts res_d is the full difference.
   assign res_d  = WIDTH'({bit_d, res_sr_q} >> 1);
   assign last_c = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_sr_q     <= '0;
         b_sr_q     <= '0;
         res_sr_q   <= '0;
         br_q       <= 1'b0;
         cnt_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_msb_q    <= 1'b0;
         b_msb_q    <= 1'b0;
         overflow   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  br_q    <= borrow_in;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               res_sr_q <= res_d;
               br_q     <= br_d;
               cnt_q    <= cnt_q + CW'(1);
               if (last_c) begin
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  diff       <= res_d;
                  borrow_out <= br_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  overflow   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
                  state_q    <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl against an arithmetic model.
// Covers the overflow output when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_sub_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         overflow;
   logic         hold_ov;
`endif

   int           checks;
   int           errors;
   logic [W-1:0] hold_diff;
   logic         hold_bo;

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
      .overflow   (overflow),
`endif
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   // Reference: unsigned a - b - bin in W+1 bits; top bit is the borrow.
   function automatic logic [W:0] model_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic bin);
      return {1'b0, av} - {1'b0, bv} - (W+1)'(bin);
   endfunction

   // Reference: true signed result leaves the W-bit two's-complement range.
   function automatic logic model_ov(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic bin);
      int sa;
      int sb;
      int sr;
      sa = $signed(av);
      sb = $signed(bv);
      sr = sa - sb - int'(bin);
      return (sr < -(1 <<< (W-1))) || (sr > (1 <<< (W-1)) - 1);
   endfunction

   // Waits for done while checking busy and result hold; then checks the result.
   task automatic wait_and_check(input string nm, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic bin, input logic rnd);
      logic [W:0] exp;
      int         lat;
      exp = model_sub(av, bv, bin);
      lat = 0;
      while (done !== 1'b1 && lat < int'(W) + 4) begin
         checks++;
         if (busy !== 1'b1 || diff !== hold_diff || borrow_out !== hold_bo) begin
            errors++;
            $display("FAIL %s_run busy=%b diff=%h bo=%b exp busy=1 diff=%h bo=%b",
                     nm, busy, diff, borrow_out, hold_diff, hold_bo);
         end
         if (rnd) begin
            a = W'($urandom);
            b = W'($urandom);
            borrow_in = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != int'(W) || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_latency got=%0d busy=%b exp=%0d busy=0", nm, lat, busy, W);
      end
      checks++;
      if (diff !== exp[W-1:0] || borrow_out !== exp[W]) begin
         errors++;
         $display("FAIL %s_result got diff=%h bo=%b exp diff=%h bo=%b",
                  nm, diff, borrow_out, exp[W-1:0], exp[W]);
      end
      hold_diff = exp[W-1:0];
      hold_bo   = exp[W];
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (overflow !== model_ov(av, bv, bin)) begin
         errors++;
         $display("FAIL %s_overflow got=%b exp=%b", nm, overflow, model_ov(av, bv, bin));
      end
      hold_ov = model_ov(av, bv, bin);
`endif
   endtask

   task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bin);
      @(negedge clk);
      a = av;
      b = bv;
      borrow_in = bin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_and_check(nm, av, bv, bin, 1'b1);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== hold_diff || borrow_out !== hold_bo) begin
         errors++;
         $display("FAIL %s_after done=%b busy=%b diff=%h bo=%b exp 0 0 %h %b",
                  nm, done, busy, diff, borrow_out, hold_diff, hold_bo);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      borrow_in = 1'b0;
      hold_diff = '0;
      hold_bo = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      hold_ov = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset busy=%b done=%b diff=%h bo=%b exp all 0",
                  busy, done, diff, borrow_out);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op("d5a_3c", 8'h5A, 8'h3C, 1'b0);
      run_op("d00_01", 8'h00, 8'h01, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if (diff !== 8'hFF || borrow_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold diff=%h bo=%b busy=%b done=%b exp ff 1 0 0",
                  diff, borrow_out, busy, done);
      end
      run_op("d10_10_b", 8'h10, 8'h10, 1'b1);
      run_op("dff_00", 8'hFF, 8'h00, 1'b0);
   endtask

   task automatic test_start_held();
      logic [W-1:0] a1, b1, a2, b2;
      logic         c1, c2;
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      @(negedge clk);
      a = a1; b = b1; borrow_in = c1; start = 1'b1;
      @(negedge clk);
      wait_and_check("held1", a1, b1, c1, 1'b1);
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL held_idle busy=%b done=%b exp 0 0", busy, done);
      end
      a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
      a = a2; b = b2; borrow_in = c2;
      @(negedge clk);
      start = 1'b0;
      wait_and_check("held2", a2, b2, c2, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_abort();
      bit saw_done;
      @(negedge clk);
      a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset busy=%b done=%b diff=%h bo=%b exp all 0",
                  busy, done, diff, borrow_out);
      end
      hold_diff = '0;
      hold_bo = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL abort_overflow got=%b exp=0", overflow);
      end
      hold_ov = 1'b0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_no_done got activity=1 exp=0");
      end
      run_op("abort_05_03", 8'h05, 8'h03, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
   task automatic test_overflow();
      run_op("ov80_01", 8'h80, 8'h01, 1'b0);
      checks++;
      if (overflow !== 1'b1 || diff !== 8'h7F) begin
         errors++;
         $display("FAIL ov80_01_const ov=%b diff=%h exp 1 7f", overflow, diff);
      end
      run_op("ov7f_ff", 8'h7F, 8'hFF, 1'b0);
      checks++;
      if (overflow !== 1'b1 || diff !== 8'h80) begin
         errors++;
         $display("FAIL ov7f_ff_const ov=%b diff=%h exp 1 80", overflow, diff);
      end
      run_op("ov05_03", 8'h05, 8'h03, 1'b0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ov05_03_const ov=%b exp 0", overflow);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_start_held();
      test_abort();
      test_random();
`ifdef SERIAL_SUB_OVERFLOW_EN
      test_overflow();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
